// File: rtl/reg_uart_if.sv
// rtl/reg_uart_if.sv - register bus bundle between the core and reg_uart
//
// Signals:
//   register_index       12  hardware register index from the core
//   register_read         1  read strobe for register_index
//   register_write        1  write strobe for register_index
//   register_write_value 16  write data
//   register_read_value  16  registered read data, zero when not selected
// Modports: master (core side), slave (peripheral side).
interface reg_uart_if;
    logic [11:0] register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;

    modport master (
        output register_index,
        output register_read,
        output register_write,
        output register_write_value,
        input  register_read_value
    );

    modport slave (
        input  register_index,
        input  register_read,
        input  register_write,
        input  register_write_value,
        output register_read_value
    );
endinterface

// File: rtl/reg_uart.sv
// rtl/reg_uart.sv - register-mapped 8N1 UART with 4-entry TX FIFO
//
// Parameters:
//   BASE_INDEX    register index of DATA; STATUS sits at BASE_INDEX+1
//   CLKS_PER_BIT  clk cycles per serial bit (minimum 4)
// Ports:
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      reg_uart_if.slave register bus
//   uart_tx  serial transmit line, idle high
//   uart_rx  serial receive line, asynchronous to clk
// Build option:
//   REG_UART_RX_EN  when defined, the receiver is built; otherwise uart_rx is
//                   ignored, DATA reads return 0 and RX status bits read 0.
// STATUS: bit0 tx_full, bit1 tx_idle, bit2 rx_valid, bit3 rx_overrun,
//         bit4 tx_overflow, bit5 rx_frame_err. Any STATUS write clears 3..5.
module reg_uart #(
    parameter logic [11:0] BASE_INDEX   = 12'h000,
    parameter logic [15:0] CLKS_PER_BIT = 16'd434
) (
    input  logic       clk,
    input  logic       reset_n,
    reg_uart_if.slave  bus,
    output logic       uart_tx,
    input  logic       uart_rx
);

    localparam logic [15:0] BIT_LAST = CLKS_PER_BIT - 16'd1;

    // ------------------------------------------------------------------
    // Register decode. A simultaneous write wins: the read is suppressed
    // entirely (no side effect, returns 0).
    // ------------------------------------------------------------------
    logic sel_data, sel_status;
    logic wr_data, wr_status, rd_data, rd_status;

    assign sel_data   = (bus.register_index == BASE_INDEX);
    assign sel_status = (bus.register_index == BASE_INDEX + 12'd1);
    assign wr_data    = bus.register_write && sel_data;
    assign wr_status  = bus.register_write && sel_status;
    assign rd_data    = bus.register_read && !bus.register_write && sel_data;
    assign rd_status  = bus.register_read && !bus.register_write && sel_status;

    // ------------------------------------------------------------------
    // TX FIFO: 3-bit pointers, occupancy is their modulo-8 difference.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t   tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;

    logic [7:0]  fifo_mem [4];
    logic [2:0]  wr_ptr, rd_ptr;
    logic [2:0]  fifo_count;
    logic        fifo_full, fifo_empty;
    logic        tx_pop, tx_push;
    logic        tx_idle, tx_overflow;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == 3'd4);
    assign fifo_empty = (fifo_count == 3'd0);

    // The shifter takes a byte either from IDLE or at the last cycle of a
    // stop bit, which is what makes back-to-back frames gap-free.
    assign tx_pop  = !fifo_empty &&
                     ((tx_state == TX_IDLE) ||
                      (tx_state == TX_STOP && tx_cnt == BIT_LAST));
    // A push into a full FIFO still fits when an entry leaves that cycle.
    assign tx_push = wr_data && (!fifo_full || tx_pop);
    assign tx_idle = fifo_empty && (tx_state == TX_IDLE);

    always_ff @(posedge clk) begin
        if (tx_push) begin
            fifo_mem[wr_ptr[1:0]] <= bus.register_write_value[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
        end else begin
            if (tx_push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_overflow <= 1'b0;
        end else if (wr_data && fifo_full && !tx_pop) begin
            tx_overflow <= 1'b1;
        end else if (wr_status) begin
            tx_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TX state machine; uart_tx is registered so the line never glitches.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= fifo_mem[rd_ptr[1:0]];
                        uart_tx  <= 1'b0;
                        tx_cnt   <= 16'd0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= 3'd0;
                        tx_cnt   <= 16'd0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= 16'd0;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            uart_tx  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= 16'd0;
                        if (tx_pop) begin
                            tx_shift <= fifo_mem[rd_ptr[1:0]];
                            uart_tx  <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: begin
                    uart_tx  <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [7:0] rx_data;
    logic       rx_valid, rx_overrun, rx_frame_err;

`ifdef REG_UART_RX_EN
    localparam logic [15:0] HALF_LAST = (CLKS_PER_BIT >> 1) - 16'd1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_meta, rx_sync, rx_prev;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Later assignments override earlier ones: a completing byte beats the
    // read-clear of rx_valid, and new error events beat a STATUS-write clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= 16'd0;
            rx_bit       <= 3'd0;
            rx_shift     <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rd_data) begin
                rx_valid <= 1'b0;
            end
            if (wr_status) begin
                rx_overrun   <= 1'b0;
                rx_frame_err <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Half a bit in: a line back high was only a glitch.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= RX_IDLE;
                        if (!rx_sync) begin
                            rx_frame_err <= 1'b1;
                        end else if (!rx_valid || rd_data) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end
`else
    assign rx_data      = 8'h00;
    assign rx_valid     = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
`endif

    // Inputs that carry no information for this block.
    logic unused_inputs;
    assign unused_inputs = ^{bus.register_write_value[15:8], uart_rx};

    // ------------------------------------------------------------------
    // Read data: one-cycle registered pulse, zero otherwise so several
    // peripherals can be ORed onto one return bus.
    // ------------------------------------------------------------------
    logic [15:0] status_word;
    assign status_word = {10'h000, rx_frame_err, tx_overflow, rx_overrun,
                          rx_valid, tx_idle, fifo_full};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.register_read_value <= 16'h0000;
        end else if (rd_data) begin
            bus.register_read_value <= {8'h00, rx_data};
        end else if (rd_status) begin
            bus.register_read_value <= status_word;
        end else begin
            bus.register_read_value <= 16'h0000;
        end
    end

endmodule

// File: tb/tb_reg_uart.sv
// tb/tb_reg_uart.sv - self-checking bench for reg_uart (CLKS_PER_BIT=4, BASE_INDEX=0x010)
module tb_reg_uart;
    localparam logic [11:0] BASE = 12'h010;
    localparam logic [11:0] STAT = 12'h011;

    logic clk = 1'b0;
    logic reset_n;
    logic uart_tx;
    logic uart_rx;

    reg_uart_if bus ();

    reg_uart #(
        .BASE_INDEX   (BASE),
        .CLKS_PER_BIT (16'd4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] rv;

    // Line recorder: one sample of uart_tx per clock, taken on the falling edge.
    logic tx_log[$];
    logic exp_wave[$];
    bit   log_en = 1'b0;

    always @(negedge clk) begin
        if (log_en) tx_log.push_back(uart_tx);
    end

    // Reference model of the receive side status.
    logic [7:0] m_data = 8'h00;
    logic       m_rxv  = 1'b0;
    logic       m_ovr  = 1'b0;
    logic       m_ferr = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_status(input logic full, input logic idle, input logic ovf);
        return {10'h000, m_ferr, ovf, m_ovr, m_rxv, idle, full};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input logic r, input logic w, input logic [11:0] idx,
                          input logic [15:0] val, output logic [15:0] rdv);
        bus.register_index       = idx;
        bus.register_read        = r;
        bus.register_write       = w;
        bus.register_write_value = val;
        @(posedge clk);
        #1;
        rdv = bus.register_read_value;
        bus.register_read  = 1'b0;
        bus.register_write = 1'b0;
    endtask

    task automatic wr(input logic [11:0] idx, input logic [15:0] val);
        logic [15:0] dummy;
        bus_op(1'b0, 1'b1, idx, val, dummy);
    endtask

    task automatic rd(input logic [11:0] idx);
        bus_op(1'b1, 1'b0, idx, 16'h0000, rv);
    endtask

    task automatic clear_status();
        wr(STAT, 16'($urandom));
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic rd_data_chk(input string tag);
        rd(BASE);
        check(tag, rv, {8'h00, m_data});
        m_rxv = 1'b0;
    endtask

    // 8N1 frame at 4 clocks per bit: 4 low, 8 data bits LSB first, 4 high.
    function automatic void add_frame(input logic [7:0] b);
        for (int k = 0; k < 40; k++) begin
            if (k < 4)       exp_wave.push_back(1'b0);
            else if (k < 36) exp_wave.push_back(b[(k - 4) / 4]);
            else             exp_wave.push_back(1'b1);
        end
    endfunction

    task automatic start_log();
        tx_log.delete();
        exp_wave.delete();
        log_en = 1'b1;
    endtask

    task automatic check_wave(input string tag, input int exp_first);
        int   first;
        int   bad;
        logic e;
        first  = -1;
        bad    = 0;
        log_en = 1'b0;
        for (int i = 0; i < tx_log.size(); i++) begin
            if (first < 0 && tx_log[i] === 1'b0) first = i;
        end
        check({tag, " start"}, 16'(first), 16'(exp_first));
        if (first >= 0) begin
            for (int i = first; i < tx_log.size(); i++) begin
                e = (i - first < exp_wave.size()) ? exp_wave[i - first] : 1'b1;
                if (tx_log[i] !== e) bad++;
            end
        end
        check({tag, " wave"}, 16'(bad), 16'h0000);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            idle(4);
        end
        uart_rx = 1'b1;
        idle(6);
`ifdef REG_UART_RX_EN
        if (!stop)       m_ferr = 1'b1;
        else if (!m_rxv) begin m_data = b; m_rxv = 1'b1; end
        else             m_ovr = 1'b1;
`endif
    endtask

    initial begin
        int          n;
        logic [7:0]  b;
        logic [15:0] v;
        logic [11:0] idx;

        bus.register_index       = 12'h000;
        bus.register_read        = 1'b0;
        bus.register_write       = 1'b0;
        bus.register_write_value = 16'h0000;
        uart_rx = 1'b1;
        reset_n = 1'b0;

        // Reset state
        idle(3);
        check("reset uart_tx", 16'(uart_tx), 16'h0001);
        check("reset read_value", bus.register_read_value, 16'h0000);
        reset_n = 1'b1;
        idle(2);
        rd(STAT);
        check("status after reset", rv, exp_status(1'b0, 1'b1, 1'b0));
        idle(1);
        check("read_value back to 0", bus.register_read_value, 16'h0000);

        // Single byte, directed then random (upper write bits must be ignored)
        start_log();
        wr(BASE, 16'h0155);
        add_frame(8'h55);
        idle(48);
        check_wave("tx 0x55", 2);
        rd(STAT);
        check("status after tx", rv, exp_status(1'b0, 1'b1, 1'b0));
        repeat (2) begin
            v = 16'($urandom);
            start_log();
            wr(BASE, v);
            add_frame(v[7:0]);
            idle(48);
            check_wave("tx random", 2);
        end

        // Back-to-back bursts: one byte goes straight to the shifter, four queue
        for (int t = 0; t < 2; t++) begin
            n = (t == 0) ? 6 : int'($urandom_range(2, 6));
            start_log();
            for (int i = 0; i < n; i++) begin
                b = (t == 0) ? 8'(i + 1) : 8'($urandom);
                wr(BASE, {8'($urandom), b});
                if (i < 5) add_frame(b);
            end
            rd(STAT);
            check("status after burst", rv, exp_status(n >= 5, 1'b0, n > 5));
            idle(210);
            check_wave("burst", 2);
            rd(STAT);
            check("status after drain", rv, exp_status(1'b0, 1'b1, n > 5));
            clear_status();
            rd(STAT);
            check("status after clear", rv, exp_status(1'b0, 1'b1, 1'b0));
        end

        // Push into a full FIFO on the exact cycle the shifter pops: accepted
        start_log();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            wr(BASE, {8'h00, b});
            add_frame(b);
        end
        idle(36);
        b = 8'($urandom);
        wr(BASE, {8'h00, b});
        add_frame(b);
        idle(250);
        check_wave("push on pop", 2);
        rd(STAT);
        check("status push on pop", rv, exp_status(1'b0, 1'b1, 1'b0));

        // Receive path (without the receiver the model stays at zero)
        send_rx(8'hA3, 1'b1);
        rd(STAT);
        check("status rx A3", rv, exp_status(1'b0, 1'b1, 1'b0));
        rd_data_chk("data rx A3");
        rd(STAT);
        check("status after data read", rv, exp_status(1'b0, 1'b1, 1'b0));
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd_data_chk("data overrun keeps first");
        rd(STAT);
        check("status overrun", rv, exp_status(1'b0, 1'b1, 1'b0));
        send_rx(8'($urandom), 1'b0);
        rd(STAT);
        check("status frame error", rv, exp_status(1'b0, 1'b1, 1'b0));
        rd_data_chk("data read when empty");
        clear_status();
        rd(STAT);
        check("status rx clear", rv, exp_status(1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 4; i++) begin
            send_rx(8'($urandom), $urandom_range(0, 3) != 0);
            rd(STAT);
            check("status rx random", rv, exp_status(1'b0, 1'b1, 1'b0));
            if ($urandom_range(0, 1) == 1) rd_data_chk("data rx random");
        end
        send_rx(8'($urandom), 1'b1);

        // Read and write together on DATA: byte queued, read returns 0
        start_log();
        v = 16'($urandom);
        bus_op(1'b1, 1'b1, BASE, v, rv);
        check("read+write value", rv, 16'h0000);
        add_frame(v[7:0]);
        idle(48);
        check_wave("read+write tx", 2);
        rd(STAT);
        check("status after read+write", rv, exp_status(1'b0, 1'b1, 1'b0));

        // Unselected indices
        rd(12'h012);
        check("unselected 0x012", rv, 16'h0000);
        idx = 12'($urandom);
        if (idx == BASE || idx == STAT) idx = 12'h7FF;
        rd(idx);
        check("unselected random", rv, 16'h0000);

        // Reset during data bit 3 with more bytes queued
        b = 8'($urandom) & 8'hF7;
        wr(BASE, {8'h00, b});
        wr(BASE, 16'($urandom));
        wr(BASE, 16'($urandom));
        idle(16);
        check("tx in bit 3", 16'(uart_tx), 16'h0000);
        reset_n = 1'b0;
        #1;
        check("tx high on reset", 16'(uart_tx), 16'h0001);
        m_data = 8'h00;
        m_rxv  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        idle(2);
        reset_n = 1'b1;
        start_log();
        idle(100);
        check_wave("after reset", -1);
        rd(STAT);
        check("status after mid-frame reset", rv, exp_status(1'b0, 1'b1, 1'b0));
        rd_data_chk("data after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_uart.md
REG_UART -- requirements
Module: reg_uart

Interface
REQ-001 SHALL have parameter BASE_INDEX, default 12'h000, register_index of the first register in this block's window.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16'd434, clk cycles per serial bit (minimum 4).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 register_index  input  12  hardware register index from the core.
REQ-006 register_read  input  1  read strobe for register_index.
REQ-007 register_write  input  1  write strobe for register_index.
REQ-008 register_write_value  input  16  write data.
REQ-009 register_read_value  output  16  read data, registered.
REQ-010 uart_tx  output  1  serial transmit line, idle high.
REQ-011 uart_rx  input  1  serial receive line, asynchronous to clk.

Function
REQ-012 SHALL decode offset 0 (DATA) at BASE_INDEX and offset 1 (STATUS) at BASE_INDEX+1; all other indices are unselected.
REQ-013 SHALL drive register_read_value on the cycle after register_read is sampled high, and drive 16'h0000 on every other cycle and for unselected indices, so multiple peripherals may be ORed.
REQ-014 When register_write and register_read are both high, the write SHALL take effect and the read SHALL have no side effect and return 0.
REQ-015 Write DATA: SHALL push register_write_value[7:0] into a 4-entry TX FIFO; bits [15:8] ignored.
REQ-016 Push while FIFO holds 4 entries SHALL drop the byte and set sticky tx_overflow, except that a push in the same cycle the shifter pops an entry SHALL be accepted (count stays 4).
REQ-017 FIFO pointers SHALL be 3 bits and wrap modulo 8; full = 4 entries, empty = 0.
REQ-018 TX state machine IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE; each state/bit lasts exactly CLKS_PER_BIT cycles.
REQ-019 IDLE with FIFO non-empty SHALL pop and drive start bit (0) on the next cycle; STOP drives 1; back-to-back bytes SHALL have no idle gap.
REQ-020 Read STATUS SHALL return bit0 tx_full, bit1 tx_idle (FIFO empty and state IDLE), bit2 rx_valid, bit3 rx_overrun, bit4 tx_overflow, bit5 rx_frame_err, bits[15:6] 0.
REQ-021 Write STATUS with any value SHALL clear bits 3, 4, 5; bits 0-2 unaffected.
REQ-022 uart_rx SHALL pass a 2-flop synchronizer before use.
REQ-023 RX state machine IDLE -> START -> DATA -> STOP; falling edge in IDLE enters START; start rechecked at CLKS_PER_BIT/2, aborting to IDLE if high; data and stop sampled at bit centers.
REQ-024 Stop bit low SHALL discard the byte and set rx_frame_err.
REQ-025 Valid byte with rx_valid=0 SHALL load rx_data and set rx_valid; with rx_valid=1 SHALL keep old byte and set rx_overrun.
REQ-026 Read DATA SHALL return {8'h00, rx_data} and clear rx_valid on that cycle; if a byte completes in the same cycle, the new byte SHALL load and rx_valid SHALL stay 1, no overrun.
REQ-027 Read DATA with rx_valid=0 SHALL return {8'h00, last rx_data} without side effect.

Reset
REQ-028 reset_n low SHALL immediately force uart_tx=1, register_read_value=0, FIFO empty, both FSMs IDLE, all status flags 0, rx_data=0.
REQ-029 Reset mid-frame SHALL abort the frame; uart_tx high from the reset assertion onward, no partial byte reported.

Configuration
REQ-030 With REG_UART_RX_EN defined, SHALL implement REQ-022..REQ-027.
REQ-031 Without REG_UART_RX_EN, SHALL omit receive logic; uart_rx port remains, ignored; DATA read returns 0; STATUS bits 2, 3, 5 read 0.

Verification (CLKS_PER_BIT=4, BASE_INDEX=12'h010)
REQ-032 Write 0x0155 to 0x010 -> uart_tx: 4 cycles low, bits 1,0,1,0,1,0,1,0 at 4 cycles each, 4 cycles high; STATUS reads 0x0002 afterward.
REQ-033 Six back-to-back DATA writes 0x01..0x06 while idle -> first five transmitted gap-free (one popped immediately), sixth dropped, STATUS bit4 set; STATUS write clears to 0x0000 after drain plus bit1.
REQ-034 Drive 0xA3 8N1 on uart_rx, read 0x010 -> 0x00A3 one cycle after strobe, STATUS bit2 then 0.
REQ-035 Two frames 0x11, 0x22 without reading -> DATA read 0x0011, STATUS bit3 set; stop bit low on third frame -> bit5 set, rx_valid unchanged.
REQ-036 Assert reset_n low during TX bit 3 -> uart_tx=1 same cycle, STATUS 0x0002 after release, no further bits.
REQ-037 Read index 0x012 -> register_read_value 0x0000; read and write strobes together on 0x010 -> byte queued, read returns 0, rx_valid unchanged.
